// File: rtl/alu_divider_if.sv
// Handshake and operand/result bundle between the ALU controller and the divider.
interface alu_divider_if #(
    parameter int unsigned WIDTH = 4
);
    logic                 START;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 BUSY;
    logic                 DONE;
    logic [2*WIDTH-1:0]   RESULT;
    logic                 DIV0;

    // Controller side: launches operations and waits for completion.
    modport master (
        output START, A, B,
        input  BUSY, DONE, RESULT, DIV0
    );

    // Divider side.
    modport slave (
        input  START, A, B,
        output BUSY, DONE, RESULT, DIV0
    );
endinterface

// File: rtl/alu_divider.sv
// Multi-cycle unsigned restoring divider. RESULT = {remainder, quotient}.
// One quotient bit per clock; divide-by-zero completes in the accepting cycle.
module alu_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    alu_divider_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state, state_d;
    // Dividend shifts out of the top while quotient bits shift into the bottom.
    logic [WIDTH-1:0]     dq, dq_d;
    logic [WIDTH-1:0]     divisor, divisor_d;
    // Partial remainder; after each restore it is below the divisor, so W bits suffice.
    logic [WIDTH-1:0]     prem, prem_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic                 busy, busy_d;
    logic                 done, done_d;
    logic                 div0, div0_d;
    logic [2*WIDTH-1:0]   result, result_d;

    logic [WIDTH:0]       p_shift;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     p_next;
    logic [WIDTH-1:0]     dq_next;

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            dq      <= '0;
            divisor <= '0;
            prem    <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            div0    <= 1'b0;
            result  <= '0;
        end else begin
            state   <= state_d;
            dq      <= dq_d;
            divisor <= divisor_d;
            prem    <= prem_d;
            cnt     <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            div0    <= div0_d;
            result  <= result_d;
        end
    end

    // Next-state, one restoring iteration, and completion outputs.
    always_comb begin
        state_d   = state;
        dq_d      = dq;
        divisor_d = divisor;
        prem_d    = prem;
        cnt_d     = cnt;
        busy_d    = busy;
        done_d    = 1'b0;
        div0_d    = div0;
        result_d  = result;

        p_shift = {prem, dq[WIDTH-1]};
        trial   = p_shift - {1'b0, divisor};
        p_next  = trial[WIDTH] ? p_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        dq_next = {dq[WIDTH-2:0], ~trial[WIDTH]};

        unique case (state)
            IDLE: begin
                if (bus.START) begin
                    if (bus.B == '0) begin
                        result_d = {bus.A, {WIDTH{1'b1}}};
                        div0_d   = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        dq_d      = bus.A;
                        divisor_d = bus.B;
                        prem_d    = '0;
                        cnt_d     = '0;
                        div0_d    = 1'b0;
                        busy_d    = 1'b1;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                prem_d = p_next;
                dq_d   = dq_next;
                cnt_d  = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    result_d = {p_next, dq_next};
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.BUSY   = busy;
    assign bus.DONE   = done;
    assign bus.DIV0   = div0;
    assign bus.RESULT = result;
endmodule

// File: tb/tb_alu_divider.sv
// Bench for alu_divider: directed cases, exhaustive sweep and random traffic
// against an arithmetic reference model.
module tb_alu_divider;
    localparam int unsigned W = 4;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;
    int   done_cnt;
    int   exp_dones;
    logic [2*W-1:0] last_exp;

    alu_divider_if #(.WIDTH(W)) dif ();

    alu_divider #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completions, sampled before the edge updates DONE.
    always @(posedge clk) begin
        if (dif.DONE === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_result(input int a, input int b);
        if (b == 0) return {W'(a), {W{1'b1}}};
        return {W'(a % b), W'(a / b)};
    endfunction

    // Launch one operation at the current negedge and wait for its completion.
    // Returns at the negedge in which DONE is observed, so a following call
    // drives START in the DONE cycle.
    task automatic run_op(input int a, input int b);
        int n;
        int busy_cyc;
        int lat;
        logic [2*W-1:0] exp;
        exp = ref_result(a, b);
        lat = (b == 0) ? 0 : int'(W);
        dif.START = 1'b1;
        dif.A = W'(a);
        dif.B = W'(b);
        @(negedge clk);
        dif.START = 1'b0;
        dif.A = W'($urandom);
        dif.B = W'($urandom);
        n = 0;
        busy_cyc = 0;
        while (dif.DONE !== 1'b1 && n < 40) begin
            if (dif.BUSY === 1'b1) busy_cyc++;
            if (n == 0) begin
                check("busy_at_accept", 32'(dif.BUSY), 32'(1));
                check("div0_cleared", 32'(dif.DIV0), 32'(0));
                check("result_held", 32'(dif.RESULT), 32'(last_exp));
            end
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(lat));
        check("result", 32'(dif.RESULT), 32'(exp));
        check("div0", 32'(dif.DIV0), 32'(b == 0));
        check("busy_at_done", 32'(dif.BUSY), 32'(0));
        check("busy_cycles", 32'(busy_cyc), 32'(lat));
        last_exp = exp;
        exp_dones++;
    endtask

    initial begin
        int n;
        int dc;
        compared = 0;
        mismatched = 0;
        done_cnt = 0;
        exp_dones = 0;
        last_exp = '0;
        rst_n = 1'b0;
        dif.START = 1'b0;
        dif.A = '0;
        dif.B = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(dif.BUSY), 32'(0));
        check("rst_done", 32'(dif.DONE), 32'(0));
        check("rst_div0", 32'(dif.DIV0), 32'(0));
        check("rst_result", 32'(dif.RESULT), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        done_cnt = 0;

        // Directed cases, including START in the DONE cycle.
        run_op(13, 3);
        @(negedge clk);
        check("done_pulse", 32'(dif.DONE), 32'(0));
        run_op(15, 1);
        run_op(2, 9);
        run_op(7, 0);
        run_op(6, 2);

        // START while busy is ignored; A/B wiggle during RUN.
        dif.START = 1'b1; dif.A = W'(9); dif.B = W'(2);
        @(negedge clk);
        dif.A = W'(1); dif.B = W'(1);
        @(negedge clk);
        dif.START = 1'b0; dif.A = W'(0); dif.B = W'(0);
        n = 1;
        while (dif.DONE !== 1'b1 && n < 40) begin
            dif.A = W'($urandom);
            dif.B = W'($urandom);
            @(negedge clk);
            n++;
        end
        check("ignore_latency", 32'(n), 32'(W));
        check("ignore_result", 32'(dif.RESULT), 32'(8'h14));
        exp_dones++;
        last_exp = 8'h14;
        @(negedge clk);
        check("ignore_single_done", 32'(dif.DONE), 32'(0));
        check("ignore_idle", 32'(dif.BUSY), 32'(0));

        // Reset in the middle of an operation.
        dif.START = 1'b1; dif.A = W'(12); dif.B = W'(5);
        @(negedge clk);
        dif.START = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(dif.BUSY), 32'(0));
        check("abort_done", 32'(dif.DONE), 32'(0));
        check("abort_div0", 32'(dif.DIV0), 32'(0));
        check("abort_result", 32'(dif.RESULT), 32'(0));
        last_exp = '0;
        dc = done_cnt;
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(dc));
        run_op(12, 5);
        check("after_abort", 32'(dif.RESULT), 32'(8'h22));

        // Exhaustive sweep, back-to-back.
        for (int b = 0; b < (1 << W); b++) begin
            for (int a = 0; a < (1 << W); a++) begin
                run_op(a, b);
            end
        end

        // Random traffic with random idle gaps.
        for (int i = 0; i < 150; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        @(negedge clk);
        @(negedge clk);
        check("done_count", 32'(done_cnt), 32'(exp_dones));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
